// File: rtl/aes_pkg.sv
// Shared AES types, constants and row-shift permutations for the encrypt and decrypt paths.
// Byte (r,c) of a state sits at big-endian bits [32c+8r +: 8], i.e. column 0 occupies the MSBs.
package aes_pkg;

  localparam int unsigned AES_NB      = 4;
  localparam int unsigned AES_WORD_W  = 32;
  localparam int unsigned AES_BYTE_W  = 8;
  localparam int unsigned AES_STATE_W = AES_NB * AES_WORD_W;
  localparam int unsigned AES_IDX_W   = $clog2(AES_STATE_W);

  typedef logic [AES_BYTE_W-1:0]  byte_t;
  typedef logic [AES_WORD_W-1:0]  word_t;
  typedef logic [AES_STATE_W-1:0] state_t;
  typedef logic [AES_IDX_W-1:0]   bit_idx_t;

  // LSB position of byte (r,c) in the packed state vector
  function automatic bit_idx_t byte_lsb(int unsigned r, int unsigned c);
    return bit_idx_t'(AES_STATE_W - AES_BYTE_W * (AES_NB * c + r + 1));
  endfunction

  // LSB position of column c in the packed state vector
  function automatic bit_idx_t col_lsb(int unsigned c);
    return bit_idx_t'(AES_STATE_W - AES_WORD_W * (c + 1));
  endfunction

  // Forward ShiftRows: out(r,c) = in(r,(c+r) mod 4)
  function automatic state_t shift_rows(state_t s);
    state_t o;
    o = '0;
    for (int unsigned c = 0; c < AES_NB; c++) begin
      for (int unsigned r = 0; r < AES_NB; r++) begin
        o[byte_lsb(r, c) +: AES_BYTE_W] = s[byte_lsb(r, (c + r) % AES_NB) +: AES_BYTE_W];
      end
    end
    return o;
  endfunction

  // Inverse ShiftRows: out(r,c) = in(r,(c-r) mod 4)
  function automatic state_t inv_shift_rows(state_t s);
    state_t o;
    o = '0;
    for (int unsigned c = 0; c < AES_NB; c++) begin
      for (int unsigned r = 0; r < AES_NB; r++) begin
        o[byte_lsb(r, c) +: AES_BYTE_W] = s[byte_lsb(r, (c + AES_NB - r) % AES_NB) +: AES_BYTE_W];
      end
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_shift_rows_perm.sv
// Combinational row-shift permutation; i_inv selects InvShiftRows, otherwise ShiftRows.
module aes_shift_rows_perm
  import aes_pkg::*;
(
  input  state_t i_state,
  input  logic   i_inv,
  output state_t o_state_c
);

  state_t w_fwd_state;
  state_t w_inv_state;

  assign w_fwd_state = shift_rows(i_state);
  assign w_inv_state = inv_shift_rows(i_state);
  assign o_state_c   = i_inv ? w_inv_state : w_fwd_state;

endmodule

// File: rtl/aes_inv_shift_rows_serial.sv
// Word-serial InvShiftRows stage: buffers a 4-column block, then streams the permuted columns.
// BUF_DEPTH = 1 (single buffer) or 2 (ping-pong, full-rate streaming).
// Optional macro AES_FWD_MODE_EN adds a per-block fwd input selecting forward ShiftRows.
module aes_inv_shift_rows_serial
  import aes_pkg::*;
#(
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [AES_WORD_W-1:0] in_word,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [AES_WORD_W-1:0] out_word,
  output logic                  out_last
`ifdef AES_FWD_MODE_EN
  ,
  input  logic                  fwd
`endif
);

  // Two physical slots; with BUF_DEPTH=1 both pointers stay at slot 0
  localparam int unsigned      NUM_BUF  = 2;
  localparam int unsigned      CNT_W    = $clog2(AES_NB);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(AES_NB - 1);

  word_t              r_buf [NUM_BUF][AES_NB];
  logic [NUM_BUF-1:0] r_full;
  logic               r_wr_ptr;
  logic               r_rd_ptr;
  logic [CNT_W-1:0]   r_wr_cnt;
  logic [CNT_W-1:0]   r_rd_cnt;

  logic   w_in_fire;
  logic   w_out_fire;
  logic   w_inv;
  logic   w_wr_ptr_nxt;
  logic   w_rd_ptr_nxt;
  state_t w_rd_state;
  state_t w_perm_state;

  // Handshakes and flags are functions of registered state only (plus reset on in_ready)
  assign in_ready   = rst_n && !r_full[r_wr_ptr];
  assign out_valid  = r_full[r_rd_ptr];
  assign out_last   = out_valid && (r_rd_cnt == CNT_LAST);
  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = out_valid && out_ready;

  assign w_wr_ptr_nxt = (BUF_DEPTH > 1) ? ~r_wr_ptr : 1'b0;
  assign w_rd_ptr_nxt = (BUF_DEPTH > 1) ? ~r_rd_ptr : 1'b0;

  // Control state: column counters, slot pointers and full flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_cnt <= '0;
      r_rd_cnt <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_full   <= '0;
    end else begin
      if (w_in_fire) begin
        r_wr_cnt <= r_wr_cnt + CNT_W'(1);
        if (r_wr_cnt == CNT_LAST) begin
          r_full[r_wr_ptr] <= 1'b1;
          r_wr_ptr         <= w_wr_ptr_nxt;
        end
      end
      // Write completes on a non-full slot, read completes on a full one: never the same bit
      if (w_out_fire) begin
        r_rd_cnt <= r_rd_cnt + CNT_W'(1);
        if (r_rd_cnt == CNT_LAST) begin
          r_full[r_rd_ptr] <= 1'b0;
          r_rd_ptr         <= w_rd_ptr_nxt;
        end
      end
    end
  end

  // Column storage; data is not cleared by reset, only the control state is
  always_ff @(posedge clk) begin
    if (w_in_fire) begin
      r_buf[r_wr_ptr][r_wr_cnt] <= in_word;
    end
  end

`ifdef AES_FWD_MODE_EN
  logic [NUM_BUF-1:0] r_fwd;

  // Block mode is captured with column 0 and travels with its slot
  always_ff @(posedge clk) begin
    if (w_in_fire && (r_wr_cnt == '0)) begin
      r_fwd[r_wr_ptr] <= fwd;
    end
  end

  assign w_inv = !r_fwd[r_rd_ptr];
`else
  assign w_inv = 1'b1;
`endif

  assign w_rd_state = {r_buf[r_rd_ptr][0], r_buf[r_rd_ptr][1],
                       r_buf[r_rd_ptr][2], r_buf[r_rd_ptr][3]};

  aes_shift_rows_perm u_perm (
    .i_state   (w_rd_state),
    .i_inv     (w_inv),
    .o_state_c (w_perm_state)
  );

  assign out_word = w_perm_state[col_lsb(32'(r_rd_cnt)) +: AES_WORD_W];

endmodule

// File: tb/tb_aes_inv_shift_rows_serial.sv
// Bench for aes_inv_shift_rows_serial: one instance per BUF_DEPTH (index 0 = depth 2, 1 = depth 1).
// Per-instance agents drive queued words, and check outputs against an independent byte model.
module tb_aes_inv_shift_rows_serial;
  import aes_pkg::*;

  typedef logic [3:0][31:0] blk_t;
  typedef struct packed { logic f; blk_t in_w; blk_t exp_w; } vec_t;
  typedef struct { word_t w; logic f; } tx_t;
  typedef struct { word_t w; logic last; } exp_t;
  typedef struct { word_t w; logic last; int cyc; } rx_t;

  logic  clk = 1'b0;
  logic  rst_n;
  logic  in_valid [2];
  logic  in_ready [2];
  word_t in_word [2];
  logic  out_valid [2];
  logic  out_ready [2];
  word_t out_word [2];
  logic  out_last [2];
`ifdef AES_FWD_MODE_EN
  logic  fwd_s [2];
`endif

  tx_t  tx_q [2][$];
  exp_t exp_q [2][$];
  rx_t  rx_q [2][$];
  int   done_q [2][$];
  int   acc_q [2][$];
  int   in_acc [2];
  int   out_cnt [2];
  int   in_mode [2];
  int   or_mode [2];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aes_inv_shift_rows_serial #(.BUF_DEPTH(2)) u_dut_d2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_word(in_word[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_word(out_word[0]),
    .out_last(out_last[0])
`ifdef AES_FWD_MODE_EN
    , .fwd(fwd_s[0])
`endif
  );

  aes_inv_shift_rows_serial #(.BUF_DEPTH(1)) u_dut_d1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_word(in_word[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_word(out_word[1]),
    .out_last(out_last[1])
`ifdef AES_FWD_MODE_EN
    , .fwd(fwd_s[1])
`endif
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Byte-level reference: column c of the permuted block
  function automatic word_t model_col(input blk_t blk, input logic f, input int c);
    word_t w;
    int    src;
    w = '0;
    for (int r = 0; r < 4; r++) begin
      src = f ? (c + r) % 4 : (c - r + 4) % 4;
      w = w | (((blk[2'(src)] >> (24 - 8 * r)) & 32'hff) << (24 - 8 * r));
    end
    return w;
  endfunction

  function automatic vec_t mk_vec(input logic f, input word_t a0, input word_t a1, input word_t a2,
                                  input word_t a3, input word_t e0, input word_t e1, input word_t e2,
                                  input word_t e3);
    vec_t v;
    v.f = f;
    v.in_w[0] = a0; v.in_w[1] = a1; v.in_w[2] = a2; v.in_w[3] = a3;
    v.exp_w[0] = e0; v.exp_w[1] = e1; v.exp_w[2] = e2; v.exp_w[3] = e3;
    return v;
  endfunction

  // Agents: sample handshakes at negedge, drive next beat 1 time unit after posedge
  for (genvar g = 0; g < 2; g++) begin : g_agent
    initial begin
      blk_t stage;
      logic stage_f;
      int   scnt;
      exp_t e;
      rx_t  rx;
      scnt = 0;
      stage = '0;
      stage_f = 1'b0;
      in_acc[g] = 0;
      out_cnt[g] = 0;
      in_valid[g] = 1'b0;
      in_word[g] = '0;
      out_ready[g] = 1'b0;
`ifdef AES_FWD_MODE_EN
      fwd_s[g] = 1'b0;
`endif
      forever begin
        @(negedge clk);
        if (!rst_n) scnt = 0;
        if (in_valid[g] && in_ready[g]) begin
          stage[2'(scnt)] = in_word[g];
          if (scnt == 0) stage_f = tx_q[g][0].f;
          void'(tx_q[g].pop_front());
          in_acc[g]++;
          acc_q[g].push_back(cyc);
          if (scnt == 3) begin
            for (int c = 0; c < 4; c++) begin
              e.w = model_col(stage, stage_f, c);
              e.last = (c == 3);
              exp_q[g].push_back(e);
            end
            done_q[g].push_back(cyc);
            scnt = 0;
          end else begin
            scnt++;
          end
        end
        if (out_valid[g] && out_ready[g]) begin
          rx.w = out_word[g];
          rx.last = out_last[g];
          rx.cyc = cyc;
          rx_q[g].push_back(rx);
          out_cnt[g]++;
          checks++;
          if (exp_q[g].size() == 0) begin
            errors++;
            $display("FAIL sb_extra_word d%0d: got %h with no word expected", g, out_word[g]);
          end else begin
            e = exp_q[g].pop_front();
            chk($sformatf("sb_word d%0d", g), 128'(out_word[g]), 128'(e.w));
            chk($sformatf("sb_last d%0d", g), 128'(out_last[g]), 128'(e.last));
          end
        end
        @(posedge clk);
        #1;
        in_valid[g] = (tx_q[g].size() > 0) && ((in_mode[g] == 0) || ($urandom_range(1) == 1));
        if (tx_q[g].size() > 0) begin
          in_word[g] = tx_q[g][0].w;
`ifdef AES_FWD_MODE_EN
          fwd_s[g] = tx_q[g][0].f;
`endif
        end
        out_ready[g] = (or_mode[g] == 1) || ((or_mode[g] == 2) && ($urandom_range(1) == 1));
      end
    end
  end

  task automatic wait_drain(input int d, input int limit);
    int n;
    n = 0;
    while ((tx_q[d].size() != 0 || exp_q[d].size() != 0) && n < limit) begin
      @(posedge clk);
      n++;
    end
    chk($sformatf("drain_pending d%0d", d), 128'(tx_q[d].size() + exp_q[d].size()), 128'(0));
  endtask

  task automatic run_vec(input int d, input vec_t v);
    tx_t t;
    int  n;
    rx_q[d].delete();
    done_q[d].delete();
    in_mode[d] = 0;
    or_mode[d] = 1;
    for (int i = 0; i < 4; i++) begin
      t.w = v.in_w[2'(i)];
      t.f = (i == 0) ? v.f : 1'b0;
      tx_q[d].push_back(t);
    end
    n = 0;
    while (rx_q[d].size() < 4 && n < 100) begin
      @(posedge clk);
      n++;
    end
    chk($sformatf("vec_beats d%0d", d), 128'(rx_q[d].size()), 128'(4));
    if (rx_q[d].size() >= 4 && done_q[d].size() >= 1) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("vec_word d%0d c%0d", d, i), 128'(rx_q[d][i].w), 128'(v.exp_w[2'(i)]));
        chk($sformatf("vec_last d%0d c%0d", d, i), 128'(rx_q[d][i].last), 128'(i == 3));
        chk($sformatf("vec_latency d%0d c%0d", d, i), 128'(rx_q[d][i].cyc - done_q[d][0]),
            128'(i + 1));
      end
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic test_stream();
    tx_t t;
    rx_q[0].delete();
    acc_q[0].delete();
    in_mode[0] = 0;
    or_mode[0] = 1;
    for (int i = 0; i < 12; i++) begin
      t.w = $urandom();
      t.f = 1'b0;
      tx_q[0].push_back(t);
    end
    wait_drain(0, 500);
    chk("stream_in_words", 128'(acc_q[0].size()), 128'(12));
    chk("stream_out_beats", 128'(rx_q[0].size()), 128'(12));
    if (acc_q[0].size() >= 12 && rx_q[0].size() >= 12) begin
      chk("stream_in_span", 128'(acc_q[0][11] - acc_q[0][0]), 128'(11));
      chk("stream_out_span", 128'(rx_q[0][11].cyc - rx_q[0][0].cyc), 128'(11));
      chk("stream_first_latency", 128'(rx_q[0][0].cyc - acc_q[0][3]), 128'(1));
    end
  endtask

  task automatic test_stall(input int d);
    tx_t t;
    int  acc0;
    acc0 = in_acc[d];
    in_mode[d] = 0;
    or_mode[d] = 0;
    for (int i = 0; i < 12; i++) begin
      t.w = $urandom();
      t.f = 1'b0;
      tx_q[d].push_back(t);
    end
    repeat (30) @(posedge clk);
    chk($sformatf("stall_accepted d%0d", d), 128'(in_acc[d] - acc0), 128'((d == 0) ? 8 : 4));
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("stall_in_ready d%0d", d), 128'(in_ready[d]), 128'(0));
      chk($sformatf("stall_out_valid d%0d", d), 128'(out_valid[d]), 128'(1));
      if (exp_q[d].size() > 0) begin
        chk($sformatf("stall_hold_word d%0d", d), 128'(out_word[d]), 128'(exp_q[d][0].w));
      end
      chk($sformatf("stall_hold_last d%0d", d), 128'(out_last[d]), 128'(0));
    end
    or_mode[d] = 1;
    wait_drain(d, 500);
  endtask

  initial begin
    vec_t tbl[$];
    tx_t  t;
    int   a0 [2];
    int   o0 [2];
    int   n;

    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      in_mode[d] = 0;
      or_mode[d] = 0;
    end
    tbl.push_back(mk_vec(1'b0, 32'h7ad5fda7, 32'h89ef4e27, 32'h2bca100b, 32'h3d9ff59f,
                         32'h7a9f1027, 32'h89d5f50b, 32'h2beffd9f, 32'h3dca4ea7));
    tbl.push_back(mk_vec(1'b0, 32'h00010203, 32'h04050607, 32'h08090a0b, 32'h0c0d0e0f,
                         32'h000d0a07, 32'h04010e0b, 32'h0805020f, 32'h0c090603));
    tbl.push_back(mk_vec(1'b0, 32'h6353e08c, 32'h0960e104, 32'hcd70b751, 32'hbacad0e7,
                         32'h63cab704, 32'h0953d051, 32'hcd60e0e7, 32'hba70e18c));
`ifdef AES_FWD_MODE_EN
    tbl.push_back(mk_vec(1'b1, 32'h63cab704, 32'h0953d051, 32'hcd60e0e7, 32'hba70e18c,
                         32'h6353e08c, 32'h0960e104, 32'hcd70b751, 32'hbacad0e7));
    tbl.push_back(mk_vec(1'b1, 32'h7a9f1027, 32'h89d5f50b, 32'h2beffd9f, 32'h3dca4ea7,
                         32'h7ad5fda7, 32'h89ef4e27, 32'h2bca100b, 32'h3d9ff59f));
`endif

    // Reset behaviour
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_in_ready d%0d", d), 128'(in_ready[d]), 128'(0));
      chk($sformatf("rst_out_valid d%0d", d), 128'(out_valid[d]), 128'(0));
      chk($sformatf("rst_out_last d%0d", d), 128'(out_last[d]), 128'(0));
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("post_rst_in_ready d%0d", d), 128'(in_ready[d]), 128'(1));
      chk($sformatf("post_rst_out_valid d%0d", d), 128'(out_valid[d]), 128'(0));
      chk($sformatf("post_rst_out_last d%0d", d), 128'(out_last[d]), 128'(0));
    end

    // Package permutation functions against fixed vectors
    chk("pkg_inv_shift_rows", inv_shift_rows(128'h7ad5fda789ef4e272bca100b3d9ff59f),
        128'h7a9f102789d5f50b2beffd9f3dca4ea7);
    chk("pkg_shift_rows", shift_rows(128'h63cab7040953d051cd60e0e7ba70e18c),
        128'h6353e08c0960e104cd70b751bacad0e7);

    // Table-driven single blocks on both depths
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < tbl.size(); i++) begin
        run_vec(d, tbl[i]);
      end
    end

    // Back-to-back streaming on the ping-pong instance
    test_stream();

    // Output stall with three blocks offered
    test_stall(0);
    test_stall(1);

    // Partial block followed by reset
    for (int d = 0; d < 2; d++) begin
      a0[d] = in_acc[d];
      in_mode[d] = 0;
      or_mode[d] = 1;
      for (int i = 0; i < 2; i++) begin
        t.w = $urandom();
        t.f = 1'b0;
        tx_q[d].push_back(t);
      end
    end
    n = 0;
    while ((in_acc[0] - a0[0] < 2 || in_acc[1] - a0[1] < 2) && n < 50) begin
      @(posedge clk);
      n++;
    end
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("partial_accepted d%0d", d), 128'(in_acc[d] - a0[d]), 128'(2));
    end
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("partial_out_valid d%0d", d), 128'(out_valid[d]), 128'(0));
      end
    end
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("partial_no_expect d%0d", d), 128'(exp_q[d].size()), 128'(0));
      run_vec(d, tbl[0]);
    end

    // Random flow control, 1000 blocks per instance
    for (int d = 0; d < 2; d++) begin
      o0[d] = out_cnt[d];
      in_mode[d] = 1;
      or_mode[d] = 2;
      rx_q[d].delete();
      acc_q[d].delete();
      done_q[d].delete();
      for (int b = 0; b < 1000; b++) begin
        for (int i = 0; i < 4; i++) begin
          t.w = $urandom();
          t.f = 1'b0;
`ifdef AES_FWD_MODE_EN
          t.f = ($urandom_range(1) == 1);
`endif
          tx_q[d].push_back(t);
        end
      end
    end
    n = 0;
    while ((tx_q[0].size() + exp_q[0].size() + tx_q[1].size() + exp_q[1].size()) != 0
           && n < 40000) begin
      @(posedge clk);
      n++;
    end
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rand_pending d%0d", d), 128'(tx_q[d].size() + exp_q[d].size()), 128'(0));
      chk($sformatf("rand_out_count d%0d", d), 128'(out_cnt[d] - o0[d]), 128'(4000));
      or_mode[d] = 1;
    end

    repeat (5) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time bound
  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
